alarm_tone_gen: RTL and testbench

- Parametrised alarm sound generator for the security alarm system.
- Compares the range-sensor distance against a programmable threshold with hysteresis.
- When armed and an object is near, emits a one-cycle trigger pulse and a gated square-wave tone on Data for the DAC decoder.
- Tone pitch rises as the object gets closer; the tone is chopped into beep on/off bursts, with optional latching until acknowledged.

---
 rtl/alarm_tone_gen.sv | 142 ++++++++++++++
 tb/tb_alarm_tone_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: distance threshold with hysteresis drives a
// distance-pitched square wave, chopped into beep bursts, with optional latch.
module alarm_tone_gen #(
  parameter int DIST_W    = 8,
  parameter int NEAR_TH   = 100,
  parameter int HYST      = 10,
  parameter int CNT_W     = 16,
  parameter int HALF_BASE = 4,
  parameter int HALF_STEP = 1,
  parameter int BEEP_ON   = 1000,
  parameter int BEEP_OFF  = 1000,
  parameter int LATCH     = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Arm,
  input  logic              Ack,
  input  logic [DIST_W-1:0] Distance,
  output logic              Data,
  output logic              Trig,
  output logic              Alarm
);

  typedef enum logic [1:0] {ST_IDLE, ST_BEEP_ON, ST_BEEP_OFF} state_t;

  // Release threshold lives in DIST_W+1 bits; if it cannot be reached by
  // any Distance value, release by distance is disabled outright.
  localparam int              CLR_SUM = NEAR_TH + HYST;
  localparam bit              CLR_OK  = (CLR_SUM <= (2**DIST_W) - 1);
  localparam logic [DIST_W:0] NEAR_V  = (DIST_W+1)'(NEAR_TH);
  localparam logic [DIST_W:0] CLR_V   = (DIST_W+1)'(CLR_SUM);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BEEP_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BEEP_OFF - 1);

  state_t           st, st_n;
  logic [CNT_W-1:0] tone_cnt, tone_n;
  logic [CNT_W-1:0] beep_cnt, beep_n;
  logic [CNT_W-1:0] half_lat, half_n;
  logic             data_n, trig_n, alarm_n;

  logic             near, clear, leave;
  logic [CNT_W-1:0] half;

  assign near  = {1'b0, Distance} < NEAR_V;
  assign clear = CLR_OK && ({1'b0, Distance} >= CLR_V);
  assign half  = CNT_W'(HALF_BASE + 32'(Distance) * HALF_STEP);
  assign leave = !Arm || (clear && ((LATCH == 0) || Ack));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      st       <= ST_IDLE;
      tone_cnt <= '0;
      beep_cnt <= '0;
      half_lat <= '0;
      Data     <= 1'b0;
      Trig     <= 1'b0;
      Alarm    <= 1'b0;
    end else begin
      st       <= st_n;
      tone_cnt <= tone_n;
      beep_cnt <= beep_n;
      half_lat <= half_n;
      Data     <= data_n;
      Trig     <= trig_n;
      Alarm    <= alarm_n;
    end
  end

  always_comb begin
    st_n    = st;
    tone_n  = tone_cnt;
    beep_n  = beep_cnt;
    half_n  = half_lat;
    data_n  = Data;
    trig_n  = 1'b0;
    alarm_n = Alarm;
    case (st)
      ST_IDLE: begin
        data_n  = 1'b0;
        alarm_n = 1'b0;
        tone_n  = '0;
        beep_n  = '0;
        if (Arm && near) begin
          st_n    = ST_BEEP_ON;
          trig_n  = 1'b1;
          alarm_n = 1'b1;
          data_n  = 1'b1;
          half_n  = half;
        end
      end
      ST_BEEP_ON: begin
        alarm_n = 1'b1;
        if (leave) begin
          st_n    = ST_IDLE;
          data_n  = 1'b0;
          alarm_n = 1'b0;
          tone_n  = '0;
          beep_n  = '0;
        end else if (beep_cnt == ON_LAST) begin
          st_n   = ST_BEEP_OFF;
          data_n = 1'b0;
          beep_n = '0;
          tone_n = '0;
        end else begin
          beep_n = beep_cnt + 1'b1;
          // Pitch is re-sampled only at a half-period boundary, so no glitch.
          if (tone_cnt == half_lat - 1'b1) begin
            data_n = !Data;
            tone_n = '0;
            half_n = half;
          end else begin
            tone_n = tone_cnt + 1'b1;
          end
        end
      end
      ST_BEEP_OFF: begin
        alarm_n = 1'b1;
        data_n  = 1'b0;
        if (leave) begin
          st_n    = ST_IDLE;
          alarm_n = 1'b0;
          tone_n  = '0;
          beep_n  = '0;
        end else if (beep_cnt == OFF_LAST) begin
          st_n   = ST_BEEP_ON;
          data_n = 1'b1;
          tone_n = '0;
          beep_n = '0;
          half_n = half;
        end else begin
          beep_n = beep_cnt + 1'b1;
        end
      end
      default: begin
        st_n    = ST_IDLE;
        data_n  = 1'b0;
        alarm_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Three configurations (unlatched, latched, unreachable release) share one
// stimulus stream; each is checked against a burst-timeline reference model.
module tb_alarm_tone_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Arm = 1'b0;
  logic       Ack = 1'b0;
  logic [7:0] Distance = 8'd0;
  logic [2:0] data, trig, alarm;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  alarm_tone_gen #(.NEAR_TH(100), .HYST(10), .HALF_BASE(2), .HALF_STEP(1),
                   .BEEP_ON(20), .BEEP_OFF(10), .LATCH(0)) u0 (
    .CLK(CLK), .RST(RST), .Arm(Arm), .Ack(Ack), .Distance(Distance),
    .Data(data[0]), .Trig(trig[0]), .Alarm(alarm[0]));
  alarm_tone_gen #(.NEAR_TH(100), .HYST(10), .HALF_BASE(2), .HALF_STEP(1),
                   .BEEP_ON(20), .BEEP_OFF(10), .LATCH(1)) u1 (
    .CLK(CLK), .RST(RST), .Arm(Arm), .Ack(Ack), .Distance(Distance),
    .Data(data[1]), .Trig(trig[1]), .Alarm(alarm[1]));
  alarm_tone_gen #(.NEAR_TH(250), .HYST(10), .HALF_BASE(2), .HALF_STEP(1),
                   .BEEP_ON(20), .BEEP_OFF(10), .LATCH(0)) u2 (
    .CLK(CLK), .RST(RST), .Arm(Arm), .Ack(Ack), .Distance(Distance),
    .Data(data[2]), .Trig(trig[2]), .Alarm(alarm[2]));

  // Model: alarm flag, position within the 30-cycle burst period, tone level
  // and the period position of the next tone edge.
  localparam int PERIOD = 30;
  localparam int ON_LEN = 20;
  int m_nth[3]   = '{100, 100, 250};
  bit m_latch[3] = '{1'b0, 1'b1, 1'b0};
  bit m_al[3], m_lvl[3], m_trig[3];
  int m_pos[3], m_next[3];

  function automatic int hf(int d);
    return (2 + d) % 65536;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input int k);
    int  d = int'(Distance);
    bit  cl = (m_nth[k] + 10 <= 255) && (d >= m_nth[k] + 10);
    int  p;
    m_trig[k] = 1'b0;
    if (!RST) begin
      m_al[k] = 1'b0;
    end else if (!m_al[k]) begin
      if (Arm && d < m_nth[k]) begin
        m_al[k] = 1'b1; m_pos[k] = 0; m_lvl[k] = 1'b1;
        m_next[k] = hf(d); m_trig[k] = 1'b1;
      end
    end else if (!Arm || (cl && (!m_latch[k] || Ack))) begin
      m_al[k] = 1'b0;
    end else begin
      p = (m_pos[k] + 1) % PERIOD;
      if (p == 0) begin
        m_lvl[k] = 1'b1; m_next[k] = hf(d);
      end else if (p < ON_LEN && p == m_next[k]) begin
        m_lvl[k] = !m_lvl[k]; m_next[k] = p + hf(d);
      end
      m_pos[k] = p;
    end
  endtask

  task automatic step(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      for (int k = 0; k < 3; k++) model_edge(k);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.Data", k),  32'(data[k]),  32'(m_al[k] && m_pos[k] < ON_LEN && m_lvl[k]));
        chk($sformatf("u%0d.Trig", k),  32'(trig[k]),  32'(m_trig[k]));
        chk($sformatf("u%0d.Alarm", k), 32'(alarm[k]), 32'(m_al[k]));
      end
    end
  endtask

  initial begin
    int sel;
    // reset held with an alarm-worthy input, then entry right after release
    RST = 1'b0; Arm = 1'b1; Distance = 8'd3;
    step(3);
    RST = 1'b1;
    step(40);
    // far then near: single trigger, tone + burst cadence
    Distance = 8'd150; step(3);
    Distance = 8'd3;   step(70);
    // hysteresis band, release, band does not re-enter
    Distance = 8'd105; step(10);
    Distance = 8'd110; step(3);
    Distance = 8'd105; step(5);
    // pitch change mid half-period
    Distance = 8'd3; step(2);
    Distance = 8'd8; step(30);
    // latched release needs Ack while clear
    Distance = 8'd120; step(5);
    Ack = 1'b1; Distance = 8'd50;  step(3);
    Distance = 8'd120; step(2);
    Ack = 1'b0;
    // Arm abort, re-arm, reset mid silence, unreachable release
    Distance = 8'd3; step(8);
    Arm = 1'b0; step(2);
    Arm = 1'b1; step(25);
    RST = 1'b0; step(1);
    RST = 1'b1;
    Distance = 8'd255; step(20);
    // randomized traffic biased around the thresholds
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 11);
        case (sel)
          0: Distance = 8'd99;   1: Distance = 8'd100;  2: Distance = 8'd105;
          3: Distance = 8'd109;  4: Distance = 8'd110;  5: Distance = 8'd3;
          6: Distance = 8'd8;    7: Distance = 8'd120;  8: Distance = 8'd249;
          9: Distance = 8'd250;  10: Distance = 8'd255;
          default: Distance = 8'($urandom_range(0, 255));
        endcase
      end
      Arm = ($urandom_range(0, 31) != 0);
      Ack = ($urandom_range(0, 5) == 0);
      RST = ($urandom_range(0, 199) != 0);
      step(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
